// File: rtl/disparity_output_stage_pkg.sv
// Shared defaults and types for the disparity output stage.
// Widths are derived from the disparity range so the stage tracks the selector upstream.
package disparity_output_stage_pkg;

    localparam int DEF_DISPARITY_RANGE = 8;
    localparam int DEF_COST_BITS       = 8;
    localparam int DEF_SCALE           = 36;
    localparam int DEF_INVALID_VALUE   = 0;
    localparam int DEF_COL_BITS        = 11;
    localparam int DEF_CNT_BITS        = 21;
    localparam int PIPE_DEPTH          = 3;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) bits++;
        return (bits == 0) ? 1 : bits;
    endfunction

    localparam int DEF_INDEX_BITS = clog2(DEF_DISPARITY_RANGE);

    typedef struct packed {
        logic de;
        logic h_sync;
        logic v_sync;
    } sync_t;

endpackage

// File: rtl/disparity_output_stage_if.sv
// Video-side bundle of the disparity output stage: selector results and sync in,
// grey pixel, realigned sync and per-frame statistics out.
interface disparity_output_stage_if
    import disparity_output_stage_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int COST_BITS  = DEF_COST_BITS,
    parameter int CNT_BITS   = DEF_CNT_BITS
);
    logic                  de_in;
    logic                  h_sync_in;
    logic                  v_sync_in;
    logic [INDEX_BITS-1:0] disp_idx_in;
    logic [COST_BITS-1:0]  min_cost_in;
    logic [COST_BITS-1:0]  cost_thresh;
    logic                  de_out;
    logic                  h_sync_out;
    logic                  v_sync_out;
    logic [7:0]            pixel_disparity;
    logic [CNT_BITS-1:0]   frame_invalid_cnt;
    logic                  frame_done;

    modport master (
        output de_in, h_sync_in, v_sync_in, disp_idx_in, min_cost_in, cost_thresh,
        input  de_out, h_sync_out, v_sync_out, pixel_disparity, frame_invalid_cnt, frame_done
    );

    modport slave (
        input  de_in, h_sync_in, v_sync_in, disp_idx_in, min_cost_in, cost_thresh,
        output de_out, h_sync_out, v_sync_out, pixel_disparity, frame_invalid_cnt, frame_done
    );
endinterface

// File: rtl/disparity_output_stage_sync_delay.sv
// Fixed-depth shift register with asynchronous reset, used to keep sync signals
// aligned with a pipelined data path.
module sync_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end

    // NOTE: clocked state uses non-blocking assignments so every stage samples pre-edge values.
    // NOTE: every stage is reset; this is a short register chain, not a RAM, and syncs must leave reset low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];
endmodule

// File: rtl/disparity_output_stage.sv
// Disparity output stage: invalidates unreliable pixels, scales the winning index to grey,
// realigns video sync to the 3-stage data path and reports per-frame invalid-pixel counts.
module disparity_output_stage
    import disparity_output_stage_pkg::*;
#(
    parameter int DISPARITY_RANGE = DEF_DISPARITY_RANGE,
    parameter int COST_BITS       = DEF_COST_BITS,
    parameter int SCALE           = DEF_SCALE,
    parameter int INVALID_VALUE   = DEF_INVALID_VALUE,
    parameter int COL_BITS        = DEF_COL_BITS,
    parameter int CNT_BITS        = DEF_CNT_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    disparity_output_stage_if.slave bus
);
    localparam int          INDEX_BITS   = clog2(DISPARITY_RANGE);
    localparam int          PROD_BITS    = 8 + INDEX_BITS;
    localparam logic [31:0] LAST_IDX     = 32'(DISPARITY_RANGE - 1);
    localparam logic [7:0]  INVALID_CODE = 8'(INVALID_VALUE);

    typedef struct packed {
        logic                  de;
        logic [INDEX_BITS-1:0] idx;
        logic [COST_BITS-1:0]  cost;
        logic [COL_BITS-1:0]   col;
    } s1_t;

    typedef struct packed {
        logic                  de;
        logic                  invalid;
        logic [INDEX_BITS-1:0] idx;
    } s2_t;

    logic [COL_BITS-1:0]  col_q, col_d;
    s1_t                  s1_q, s1_d;
    s2_t                  s2_q, s2_d;
    logic                 invalid;
    logic [PROD_BITS-1:0] prod;
    logic [7:0]           pix_q, pix_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CNT_BITS-1:0]  frame_cnt_q, frame_cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic                 vs_prev_q, vs_prev_d;
    logic                 vs_rise;
    sync_t                sync_in, sync_out;

    assign sync_in = '{de: bus.de_in, h_sync: bus.h_sync_in, v_sync: bus.v_sync_in};

    sync_delay #(.WIDTH($bits(sync_t)), .DEPTH(PIPE_DEPTH)) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (sync_in),
        .dout (sync_out)
    );

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        col_d = '0;
        if (bus.de_in) col_d = (&col_q) ? col_q : col_q + 1'b1;
        s1_d = '{de: bus.de_in, idx: bus.disp_idx_in, cost: bus.min_cost_in, col: col_q};
    end

    // Left-edge columns have no full right-image window yet, so they are never trusted.
    always_comb begin
        invalid = (32'(s1_q.col) < LAST_IDX) | (s1_q.cost > bus.cost_thresh)
                | (32'(s1_q.idx) > LAST_IDX);
        s2_d = '{de: s1_q.de, invalid: invalid, idx: s1_q.idx};
    end

    always_comb begin
        prod  = PROD_BITS'(s2_q.idx) * PROD_BITS'(SCALE);
        pix_d = '0;
        if (s2_q.de) begin
            if (s2_q.invalid)               pix_d = INVALID_CODE;
            else if (prod > PROD_BITS'(255)) pix_d = 8'hFF;
            else                            pix_d = prod[7:0];
        end
    end

    // A pixel judged in the frame-end cycle still belongs to the frame being closed.
    always_comb begin
        vs_prev_d    = bus.v_sync_in;
        vs_rise      = bus.v_sync_in & ~vs_prev_q;
        cnt_inc      = cnt_q;
        if (s1_q.de && invalid && !(&cnt_q)) cnt_inc = cnt_q + 1'b1;
        cnt_d        = vs_rise ? '0 : cnt_inc;
        frame_cnt_d  = vs_rise ? cnt_inc : frame_cnt_q;
        frame_done_d = vs_rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            pix_q        <= '0;
            cnt_q        <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            vs_prev_q    <= 1'b0;
        end else begin
            col_q        <= col_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            pix_q        <= pix_d;
            cnt_q        <= cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            vs_prev_q    <= vs_prev_d;
        end
    end

    assign bus.de_out            = sync_out.de;
    assign bus.h_sync_out        = sync_out.h_sync;
    assign bus.v_sync_out        = sync_out.v_sync;
    assign bus.pixel_disparity   = pix_q;
    assign bus.frame_invalid_cnt = frame_cnt_q;
    assign bus.frame_done        = frame_done_q;
endmodule
